timer_counter: RTL and testbench

Memory-mapped countdown timer on the CPU's peripheral bus, directly downstream of the bus bridge that decodes addresses 0x7f00–0x7f0b (Timer1) and 0x7f10–0x7f1b (Timer2); two instances are built, one per window. It holds three word registers (CTRL, PRESET, COUNT) addressed by `addr[3:2]`. It counts down from PRESET under a 4-state FSM and raises an interrupt request toward the CPU's interrupt logic, either one-shot (mode 0) or auto-reload (mode 1).

---
 rtl/timer_counter.sv | 98 +++++++++
 tb/tb_timer_counter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, 4-state count FSM,
// one-shot or auto-reload expiry with a maskable interrupt request.
module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t      state;
  logic [31:0] ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        flag;

  logic [31:0] ctrl_d;
  logic        flag_d;
  logic        ctrl_wr;
  logic        preset_wr;
  logic        auto_mode;
  logic        expire;
  logic        unused_addr;

  assign ctrl_wr     = we && (addr[3:2] == 2'd0);
  assign preset_wr   = we && (addr[3:2] == 2'd1);
  assign auto_mode   = (ctrl[2:1] == 2'b01);
  assign expire      = (state == CNT) && ctrl[0] && (count <= 32'd1);
  assign unused_addr = ^addr[31:4];

  // A CPU write to CTRL overrides the one-shot EN clear issued from INT.
  always_comb begin
    ctrl_d = ctrl;
    if ((state == INT) && !auto_mode)
      ctrl_d[0] = 1'b0;
    if (ctrl_wr)
      ctrl_d = {28'd0, din[3:0]};
  end

  // Expiry sets the flag even if a CTRL write would clear it in the same cycle.
  always_comb begin
    flag_d = flag;
    if (ctrl_wr || ((state == INT) && auto_mode))
      flag_d = 1'b0;
    if (expire)
      flag_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      ctrl   <= 32'd0;
      preset <= 32'd0;
      count  <= 32'd0;
      flag   <= 1'b0;
      irq    <= 1'b0;
    end else begin
      ctrl <= ctrl_d;
      flag <= flag_d;
      irq  <= flag_d & ctrl_d[3];
      if (preset_wr)
        preset <= din;
      case (state)
        IDLE: if (ctrl[0]) state <= LOAD;
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!ctrl[0]) begin
            state <= IDLE;
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            count <= 32'd0;
            state <= INT;
          end
        end
        INT:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    case (addr[3:2])
      2'd0:    dout = ctrl;
      2'd1:    dout = preset;
      2'd2:    dout = count;
      default: dout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_timer_counter.sv
// Randomized self-checking bench for timer_counter; expectations come from
// closed-form timing of the countdown (interrupt edge, reload period, count value).
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:2] addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  timer_counter dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  // Edge (counted from the enabling CTRL write) after which INT/irq appear.
  function automatic int first_int(input int n);
    return ((n < 1) ? 1 : n) + 2;
  endfunction

  function automatic int period(input int n);
    return ((n < 1) ? 1 : n) + 3;
  endfunction

  // COUNT after edge k (k >= 2) of a run started with PRESET = n.
  function automatic int exp_count(input int n, input int k);
    int v;
    v = n - (k - 2);
    return (v < 0) ? 0 : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = {28'd0, a};
    din  = d;
    we   = 1'b1;
    tick();
    we   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    we   = 1'b0;
    addr = {28'd0, a};
    #1;
    d = dout;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    reset = 1'b0;
    we    = 1'b0;
    addr  = '0;
    din   = '0;
    #2;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), r);
      checks++;
      if (r !== 32'd0) begin
        failures++;
        $display("FAIL reset_reg%0d got=%h want=0", a, r);
      end
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_irq got=%b want=0", irq);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    tick();
    tick();
    rd(2'd2, r);
    checks++;
    if (r !== 32'd5) begin
      failures++;
      $display("FAIL midcount_pre got=%0d want=5", r);
    end
    #2;
    reset = 1'b0;
    #1;
    rd(2'd2, r);
    checks++;
    if (r !== 32'd0) begin
      failures++;
      $display("FAIL async_count got=%0d want=0", r);
    end
    rd(2'd0, r);
    checks++;
    if (r !== 32'd0) begin
      failures++;
      $display("FAIL async_ctrl got=%h want=0", r);
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL async_irq got=%b want=0", irq);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= first_int(2); k++) begin
      tick();
      checks++;
      if (irq !== (k >= first_int(2))) begin
        failures++;
        $display("FAIL post_reset_irq edge=%0d got=%b want=%b", k, irq, (k >= first_int(2)));
      end
    end
    tick();
    wr(2'd0, 32'd0);
  endtask

  task automatic test_oneshot();
    logic [31:0] r;
    logic [31:0] cval;
    int n, t;
    logic im;
    logic [1:0] mode;
    for (int round = 0; round < 6; round++) begin
      n    = (round == 0) ? 5 : (round == 1) ? 0 : (round == 2) ? 1 : int'($urandom_range(0, 12));
      im   = (round < 3) ? 1'b1 : 1'($urandom_range(0, 1));
      mode = (round < 3) ? 2'b00 : ((2'($urandom_range(0, 2)) == 2'd1) ? 2'b11 : 2'($urandom_range(0, 1) * 2));
      cval = {28'd0, im, mode, 1'b1};
      t    = first_int(n);
      wr(2'd1, 32'(n));
      wr(2'd0, cval);
      for (int k = 1; k <= t + 3; k++) begin
        tick();
        if (k >= 2) begin
          rd(2'd2, r);
          checks++;
          if (r !== 32'(exp_count(n, k))) begin
            failures++;
            $display("FAIL oneshot_count n=%0d edge=%0d got=%0d want=%0d", n, k, r, exp_count(n, k));
          end
        end
        rd(2'd0, r);
        checks++;
        if (r !== ((k >= t + 1) ? {cval[31:1], 1'b0} : cval)) begin
          failures++;
          $display("FAIL oneshot_ctrl n=%0d edge=%0d got=%h want=%h", n, k, r,
                   ((k >= t + 1) ? {cval[31:1], 1'b0} : cval));
        end
        checks++;
        if (irq !== (im && (k >= t))) begin
          failures++;
          $display("FAIL oneshot_irq n=%0d edge=%0d got=%b want=%b", n, k, irq, (im && (k >= t)));
        end
      end
      wr(2'd0, 32'd0);
      checks++;
      if (irq !== 1'b0) begin
        failures++;
        $display("FAIL oneshot_clear n=%0d got=%b want=0", n, irq);
      end
    end
  endtask

  task automatic test_autoreload();
    logic [31:0] r;
    int n, t, p;
    logic want;
    for (int round = 0; round < 3; round++) begin
      n = (round == 0) ? 3 : int'($urandom_range(0, 6));
      t = first_int(n);
      p = period(n);
      wr(2'd1, 32'(n));
      wr(2'd0, 32'hB);
      for (int k = 1; k <= t + 3 * p; k++) begin
        tick();
        want = (k >= t) && (((k - t) % p) == 0);
        checks++;
        if (irq !== want) begin
          failures++;
          $display("FAIL auto_irq n=%0d edge=%0d got=%b want=%b", n, k, irq, want);
        end
        rd(2'd0, r);
        checks++;
        if (r !== 32'hB) begin
          failures++;
          $display("FAIL auto_ctrl n=%0d edge=%0d got=%h want=b", n, k, r);
        end
      end
      wr(2'd0, 32'd0);
      for (int i = 0; i < 4; i++) tick();
    end
  endtask

  task automatic test_disable();
    logic [31:0] r;
    int n, d, m, held, t;
    for (int round = 0; round < 3; round++) begin
      n = (round == 0) ? 10 : int'($urandom_range(5, 20));
      d = (round == 0) ? 7 : int'($urandom_range(3, n));
      m = (round == 0) ? 2 : int'($urandom_range(0, 6));
      held = n - d + 2;
      wr(2'd1, 32'(n));
      wr(2'd0, 32'h9);
      for (int k = 1; k < d; k++) tick();
      wr(2'd0, 32'h8);
      for (int i = 0; i < 4; i++) begin
        rd(2'd2, r);
        checks++;
        if (r !== 32'(held)) begin
          failures++;
          $display("FAIL disable_hold n=%0d d=%0d got=%0d want=%0d", n, d, r, held);
        end
        tick();
      end
      t = first_int(m);
      wr(2'd1, 32'(m));
      wr(2'd0, 32'h9);
      for (int k = 1; k <= t + 1; k++) begin
        tick();
        if (k == 2) begin
          rd(2'd2, r);
          checks++;
          if (r !== 32'(m)) begin
            failures++;
            $display("FAIL reenable_load m=%0d got=%0d want=%0d", m, r, m);
          end
        end
        checks++;
        if (irq !== (k >= t)) begin
          failures++;
          $display("FAIL reenable_irq m=%0d edge=%0d got=%b want=%b", m, k, irq, (k >= t));
        end
      end
      wr(2'd0, 32'd0);
    end
  endtask

  task automatic test_preset_during_cnt();
    logic [31:0] r;
    logic [31:0] np;
    int n;
    n  = int'($urandom_range(8, 12));
    np = 32'($urandom_range(1, 3));
    wr(2'd1, 32'(n));
    wr(2'd0, 32'h1);
    for (int k = 1; k <= n + 3; k++) begin
      if (k == 4) wr(2'd1, np);
      else tick();
      if (k >= 2) begin
        rd(2'd2, r);
        checks++;
        if (r !== 32'(exp_count(n, k))) begin
          failures++;
          $display("FAIL preset_midcnt edge=%0d got=%0d want=%0d", k, r, exp_count(n, k));
        end
      end
      checks++;
      if (irq !== 1'b0) begin
        failures++;
        $display("FAIL masked_irq edge=%0d got=%b want=0", k, irq);
      end
    end
    rd(2'd1, r);
    checks++;
    if (r !== np) begin
      failures++;
      $display("FAIL preset_readback got=%0d want=%0d", r, np);
    end
    wr(2'd0, 32'd0);
  endtask

  task automatic test_unmapped();
    logic [31:0] r;
    wr(2'd1, 32'd7);
    wr(2'd0, 32'h1);
    for (int k = 1; k < 5; k++) tick();
    wr(2'd0, 32'd0);
    tick();
    tick();
    wr(2'd2, 32'hFFFF);
    wr(2'd3, $urandom);
    rd(2'd0, r);
    checks++;
    if (r !== 32'd0) begin
      failures++;
      $display("FAIL unmapped_ctrl got=%h want=0", r);
    end
    rd(2'd1, r);
    checks++;
    if (r !== 32'd7) begin
      failures++;
      $display("FAIL unmapped_preset got=%0d want=7", r);
    end
    rd(2'd2, r);
    checks++;
    if (r !== 32'd4) begin
      failures++;
      $display("FAIL unmapped_count got=%0d want=4", r);
    end
    rd(2'd3, r);
    checks++;
    if (r !== 32'd0) begin
      failures++;
      $display("FAIL unmapped_reg3 got=%h want=0", r);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    int n, t;
    n = int'($urandom_range(1, 5));
    t = first_int(n);
    wr(2'd1, 32'(n));
    wr(2'd0, 32'h9);
    for (int k = 1; k <= t; k++) tick();
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first_irq got=%b want=1", irq);
    end
    wr(2'd0, 32'h9);
    rd(2'd0, r);
    checks++;
    if (r !== 32'h9) begin
      failures++;
      $display("FAIL cpu_wins_ctrl got=%h want=9", r);
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL cpu_write_clears got=%b want=0", irq);
    end
    for (int j = 1; j <= t; j++) begin
      tick();
      checks++;
      if (irq !== (j >= t)) begin
        failures++;
        $display("FAIL b2b_rerun_irq edge=%0d got=%b want=%b", j, irq, (j >= t));
      end
    end
    tick();
    wr(2'd0, 32'd0);
    wr(2'd0, 32'h9);
    for (int k = 1; k < t; k++) tick();
    wr(2'd0, 32'h8);
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL set_wins_irq got=%b want=1", irq);
    end
    tick();
    rd(2'd0, r);
    checks++;
    if (r !== 32'h8 || irq !== 1'b1) begin
      failures++;
      $display("FAIL set_wins_hold ctrl=%h irq=%b want ctrl=8 irq=1", r, irq);
    end
    wr(2'd0, 32'd0);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL set_wins_clear got=%b want=0", irq);
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_autoreload();
    test_disable();
    test_preset_during_cnt();
    test_unmapped();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
